seg_scan_ctrl: RTL and testbench

Dynamic-indication scan controller for the 8-digit seven-segment display on the board. It time-multiplexes one shared BCD-to-segment decoder across all digits. Each scan slot it presents one 4-bit digit code (routed to the decoder input) and drives one active-low anode and the decimal point. Display contents are loaded through a double-buffered interface and take effect only at frame boundaries, so a frame never mixes old and new data.

---
 rtl/seg_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed scan controller for an 8-digit seven-segment display
//
// Purpose:
//   Steps through the digits one slot at a time and presents one 4-bit code to a
//   shared BCD-to-segment decoder. It also drives one active-low anode and the
//   decimal point for the current slot. New display contents go into a pending
//   buffer and are copied to the active buffer only on a frame boundary, so no
//   frame ever shows a mix of old and new data.
//
// Ports:
//   clk_i    in   1   system clock
//   rst_i    in   1   asynchronous reset, active-high
//   load_i   in   1   single-cycle load strobe for data_i/mask_i/dp_i
//   data_i   in  32   digit codes, digit k = data_i[4k+3:4k], k=0 rightmost
//   mask_i   in   8   per-digit enable, 0 keeps the digit dark
//   dp_i     in   8   per-digit decimal point, 1 = lit
//   dig_o    out  4   code of the current digit (decoder input)
//   an_o     out  8   anodes, active-low, at most one low at a time
//   dp_o     out  1   decimal point, active-low
//   frame_o  out  1   one-cycle pulse after each frame boundary
//   busy_o   out  1   a loaded update is waiting for the next boundary

module seg_scan_ctrl #(
  parameter int DIGITS   = 8,
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [7:0]  mask_i,
  input  logic [7:0]  dp_i,
  output logic [3:0]  dig_o,
  output logic [7:0]  an_o,
  output logic        dp_o,
  output logic        frame_o,
  output logic        busy_o
);

  localparam int IDX_W = 3;
  localparam int CNT_W = $clog2(PRESCALE);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;

  // Active buffer (what is being displayed)
  logic [31:0] act_data, act_data_nxt;
  logic [7:0]  act_mask, act_mask_nxt;
  logic [7:0]  act_dp,   act_dp_nxt;

  // Pending buffer (what the next boundary will apply)
  logic [31:0] pnd_data, pnd_data_nxt;
  logic [7:0]  pnd_mask, pnd_mask_nxt;
  logic [7:0]  pnd_dp,   pnd_dp_nxt;
  logic        pend,     pend_nxt;

  // Registered-output next values
  logic [3:0]  dig_nxt;
  logic [7:0]  an_nxt;
  logic        dp_nxt;

  logic        tick;
  logic        boundary;
  logic        slot_on;

  always_comb begin
    tick         = 1'b0;
    boundary     = 1'b0;
    slot_on      = 1'b0;
    cnt_nxt      = cnt;
    idx_nxt      = idx;
    act_data_nxt = act_data;
    act_mask_nxt = act_mask;
    act_dp_nxt   = act_dp;
    pnd_data_nxt = pnd_data;
    pnd_mask_nxt = pnd_mask;
    pnd_dp_nxt   = pnd_dp;
    pend_nxt     = pend;
    dig_nxt      = 4'd0;
    an_nxt       = 8'hFF;
    dp_nxt       = 1'b1;

    // Prescaler and digit index
    tick = (cnt == CNT_LAST);
    if (tick) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    boundary = tick && (idx == IDX_LAST);

    // The boundary copy reads the pending buffer as it was before this edge.
    // A load on the same edge therefore refills the buffer and keeps pend set,
    // so that load applies one frame later.
    if (boundary && pend) begin
      act_data_nxt = pnd_data;
      act_mask_nxt = pnd_mask;
      act_dp_nxt   = pnd_dp;
    end

    if (load_i) begin
      pnd_data_nxt = data_i;
      pnd_mask_nxt = mask_i;
      pnd_dp_nxt   = dp_i;
      pend_nxt     = 1'b1;
    end else if (boundary) begin
      pend_nxt     = 1'b0;
    end

    // Outputs are built from post-edge state so that they line up with cnt/idx.
    // The first BLANK cycles of every slot keep all anodes off. This stops the
    // previous digit's segments from ghosting onto the new anode.
    slot_on = (cnt_nxt >= CNT_BLANK);
    dig_nxt = act_data_nxt[4*idx_nxt +: 4];
    if (slot_on && act_mask_nxt[idx_nxt]) begin
      an_nxt[idx_nxt] = 1'b0;
    end
    dp_nxt = slot_on ? ~(act_dp_nxt[idx_nxt] & act_mask_nxt[idx_nxt]) : 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt      <= '0;
      idx      <= '0;
      act_data <= '0;
      act_mask <= '0;
      act_dp   <= '0;
      pnd_data <= '0;
      pnd_mask <= '0;
      pnd_dp   <= '0;
      pend     <= 1'b0;
      dig_o    <= 4'd0;
      an_o     <= 8'hFF;
      dp_o     <= 1'b1;
      frame_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      act_data <= act_data_nxt;
      act_mask <= act_mask_nxt;
      act_dp   <= act_dp_nxt;
      pnd_data <= pnd_data_nxt;
      pnd_mask <= pnd_mask_nxt;
      pnd_dp   <= pnd_dp_nxt;
      pend     <= pend_nxt;
      dig_o    <= dig_nxt;
      an_o     <= an_nxt;
      dp_o     <= dp_nxt;
      frame_o  <= boundary;
      busy_o   <= pend_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl (PRESCALE=4, BLANK=1)

module tb_seg_scan_ctrl;

  localparam int P  = 4;
  localparam int B  = 1;
  localparam int FR = 8 * P;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        load_i;
  logic [31:0] data_i;
  logic [7:0]  mask_i;
  logic [7:0]  dp_i;
  logic [3:0]  dig_o;
  logic [7:0]  an_o;
  logic        dp_o;
  logic        frame_o;
  logic        busy_o;

  seg_scan_ctrl #(.DIGITS(8), .PRESCALE(P), .BLANK(B)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (load_i),
    .data_i  (data_i),
    .mask_i  (mask_i),
    .dp_i    (dp_i),
    .dig_o   (dig_o),
    .an_o    (an_o),
    .dp_o    (dp_o),
    .frame_o (frame_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] an;
    logic       dp;
    logic       frame;
    logic       busy;
  } obs_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
    logic [7:0]  dp;
    logic [3:0]  dig3;
    logic [7:0]  lit;
  } vec_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Bench-side picture of the display: k counts edges since reset release.
  int          k;
  int          cur_idx, cur_cnt;
  logic [31:0] m_data, pd_data;
  logic [7:0]  m_mask, pd_mask, m_dp, pd_dp;
  logic        m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s k=%0d: got %h want %h", name, k, act, req);
    end
  endtask

  task automatic model_reset();
    k = 0; cur_idx = 0; cur_cnt = 0;
    m_data = '0; m_mask = '0; m_dp = '0;
    pd_data = '0; pd_mask = '0; pd_dp = '0;
    m_pend = 1'b0;
  endtask

  // Drive one cycle, push the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic ld, input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
    logic bnd;
    int   c, ix;
    obs_t e, got;
    load_i = ld; data_i = d; mask_i = m; dp_i = p;
    bnd = ((k % FR) == FR - 1);
    if (bnd && m_pend) begin
      m_data = pd_data; m_mask = pd_mask; m_dp = pd_dp;
    end
    if (ld) begin
      pd_data = d; pd_mask = m; pd_dp = p; m_pend = 1'b1;
    end else if (bnd) begin
      m_pend = 1'b0;
    end
    k++;
    c  = k % P;
    ix = (k / P) % 8;
    e.dig = m_data[4*ix +: 4];
    e.an  = 8'hFF;
    if (c >= B && m_mask[ix]) e.an[ix] = 1'b0;
    e.dp    = (c >= B) ? ~(m_dp[ix] & m_mask[ix]) : 1'b1;
    e.frame = bnd;
    e.busy  = m_pend;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    load_i  = 1'b0;
    cur_idx = ix;
    cur_cnt = c;
    got = {dig_o, an_o, dp_o, frame_o, busy_o};
    e = exp_q.pop_front();
    check("scan", 32'(got), 32'(e));
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 8'h0, 8'h0);
  endtask

  // Free-running invariants: one anode at most, and exact frame period.
  int gap = 0;
  bit seen = 1'b0;
  always @(negedge clk_i) begin
    if (rst_i === 1'b1) begin
      seen <= 1'b0;
      gap  <= 0;
    end else if (rst_i === 1'b0) begin
      check("one_hot", 32'($countones(~an_o) <= 1), 32'd1);
      if (frame_o) begin
        if (seen) check("frame_period", 32'(gap + 1), 32'(FR));
        seen <= 1'b1;
        gap  <= 0;
      end else begin
        gap <= gap + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl[4];
    logic [7:0]  lit;
    logic [3:0]  d3;

    tbl[0] = '{data: 32'h76543210, mask: 8'hFF, dp: 8'h00, dig3: 4'h3, lit: 8'hFF};
    tbl[1] = '{data: 32'hFEDCBA98, mask: 8'h05, dp: 8'h04, dig3: 4'hB, lit: 8'h05};
    tbl[2] = '{data: 32'hDEADBEEF, mask: 8'hA5, dp: 8'hFF, dig3: 4'hB, lit: 8'hA5};
    tbl[3] = '{data: 32'h0000A000, mask: 8'h00, dp: 8'hFF, dig3: 4'hA, lit: 8'h00};

    rst_i = 1'b1; load_i = 1'b0; data_i = '0; mask_i = '0; dp_i = '0;
    model_reset();
    @(posedge clk_i); #1;
    check("reset_out", 32'({dig_o, an_o, dp_o, frame_o, busy_o}), 32'({4'd0, 8'hFF, 1'b1, 1'b0, 1'b0}));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Table-driven frames: load, wait for the boundary, observe one full frame.
    for (int r = 0; r < 4; r++) begin
      step(1'b1, tbl[r].data, tbl[r].mask, tbl[r].dp);
      if (r == 0) check("busy_after_load", 32'(busy_o), 32'd1);
      while (k % FR != 0) idle();
      lit = ~an_o;
      d3  = 4'hX;
      for (int i = 0; i < FR; i++) begin
        idle();
        lit = lit | ~an_o;
        if (cur_idx == 3 && cur_cnt == P - 1) d3 = dig_o;
        if (r == 0 && i < FR - 1) check("dig_is_idx", 32'(dig_o), 32'(cur_idx));
        if (r == 1 && i < FR - 1)
          check("dp_mask", 32'(dp_o), (cur_idx == 2 && cur_cnt >= B) ? 32'd0 : 32'd1);
      end
      check("lit_set", 32'(lit), 32'(tbl[r].lit));
      check("dig3", 32'(d3), 32'(tbl[r].dig3));
    end

    // Double load before the boundary, then a load on the boundary edge itself.
    step(1'b1, 32'h11111111, 8'hFF, 8'h00);
    idle(); idle(); idle();
    step(1'b1, 32'h22222222, 8'hFF, 8'h00);
    while (k % FR != FR - 1) idle();
    step(1'b1, 32'h33333333, 8'hFF, 8'h00);
    check("busy_across_bnd", 32'(busy_o), 32'd1);
    check("frame_a_dig", 32'(dig_o), 32'h2);
    for (int i = 0; i < FR - 1; i++) begin
      idle();
      check("frame_a_dig", 32'(dig_o), 32'h2);
    end
    idle();
    check("frame_b_dig", 32'(dig_o), 32'h3);
    check("busy_cleared", 32'(busy_o), 32'd0);
    for (int i = 0; i < FR - 1; i++) begin
      idle();
      check("frame_b_dig", 32'(dig_o), 32'h3);
    end

    // Reset mid-frame at idx=5, cnt=2 with an update pending.
    step(1'b1, 32'h87654321, 8'hFF, 8'hFF);
    while (k % FR != 22) idle();
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    #1;
    check("rst_async", 32'({dig_o, an_o, busy_o, dp_o, frame_o}), 32'({4'd0, 8'hFF, 1'b0, 1'b1, 1'b0}));
    @(posedge clk_i); #1;
    check("rst_hold", 32'({dig_o, an_o, busy_o}), 32'({4'd0, 8'hFF, 1'b0}));
    rst_i = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FR; i++) begin
      idle();
      check("dark_after_rst", 32'(an_o), 32'hFF);
    end

    // Random loads over ten frames; the monitor checks the invariants.
    for (int i = 0; i < 10 * FR; i++) begin
      if ($urandom_range(0, 11) == 0)
        step(1'b1, $urandom, 8'($urandom), 8'($urandom));
      else
        idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
